// File: rtl/arc4_pkg.sv
// Shared types, constants and key helper for the ARC4 encryption datapath.
package arc4_pkg;

    localparam int         SBOX_SIZE     = 256;
    localparam logic [7:0] LEN_ADDR      = 8'h00;
    localparam int         KEY_BYTES_MAX = 16;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA_READ_SI,
        ST_KSA_WAIT_SI,
        ST_KSA_READ_SJ,
        ST_KSA_WAIT_SJ,
        ST_KSA_WRITE_SI,
        ST_KSA_WRITE_SJ,
        ST_LEN_READ,
        ST_LEN_WAIT,
        ST_LEN_WRITE,
        ST_PRGA_READ_SI,
        ST_PRGA_WAIT_SI,
        ST_PRGA_READ_SJ,
        ST_PRGA_WAIT_SJ,
        ST_PRGA_WRITE_SI,
        ST_PRGA_WRITE_SJ,
        ST_PRGA_READ_PAD,
        ST_PRGA_WAIT_PAD,
        ST_PRGA_WRITE_CT,
        ST_DONE
    } arc4_state_e;

    // Byte idx of an nbytes-wide key held right-aligned in key; byte 0 is the MSB byte.
    function automatic logic [7:0] keybyte(input logic [8*KEY_BYTES_MAX-1:0] key,
                                           input logic [7:0] nbytes,
                                           input logic [7:0] idx);
        logic [8*KEY_BYTES_MAX-1:0] shifted;
        logic [7:0]                 pos;
        pos     = nbytes - idx - 8'd1;
        shifted = key >> {pos, 3'b000};
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/arc4_encrypt_if.sv
// Handshake and PT/CT memory bus of the ARC4 encryptor.
interface arc4_encrypt_if #(parameter int KEY_BYTES = 3);
    logic                   en;
    logic                   rdy;
    logic [8*KEY_BYTES-1:0] key;
    logic [7:0]             pt_addr;
    logic [7:0]             pt_rddata;
    logic [7:0]             ct_addr;
    logic [7:0]             ct_wrdata;
    logic                   ct_wren;

    modport master (output en, key, pt_rddata,
                    input  rdy, pt_addr, ct_addr, ct_wrdata, ct_wren);
    modport slave  (input  en, key, pt_rddata,
                    output rdy, pt_addr, ct_addr, ct_wrdata, ct_wren);
endinterface

// File: rtl/s_mem.sv
// 256x8 single-port synchronous RAM holding the ARC4 S-box.
module s_mem
    import arc4_pkg::*;
(
    input  logic [7:0] address,
    input  logic       clock,
    input  logic [7:0] data,
    input  logic       wren,
    output logic [7:0] q
);

    logic [7:0] mem_q [SBOX_SIZE];

    // Registered read port with write-enable.
    always_ff @(posedge clock) begin
        if (wren) begin
            mem_q[address] <= data;
        end
        q <= mem_q[address];
    end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: INIT, KSA and PRGA over a private S-box, length-prefixed PT -> CT.
module arc4_encrypt
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
)(
    input  logic           clk,
    input  logic           rst,
    arc4_encrypt_if.slave  bus_if
);

    localparam logic [7:0] KEY_NUM  = 8'(KEY_BYTES);
    localparam logic [7:0] KEY_LAST = 8'(KEY_BYTES - 1);

    arc4_state_e            state_q;
    logic                   rdy_q;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [7:0]             i_q, j_q, kidx_q, len_q, si_q, sj_q, pt_q;
    logic [8:0]             k_q;
    logic [7:0]             s_addr_q, s_data_q;
    logic                   s_wren_q;
    logic [7:0]             pt_addr_q, ct_addr_q, ct_wrdata_q;
    logic                   ct_wren_q;

    logic [8*KEY_BYTES_MAX-1:0] key_ext_s;
    logic [7:0]                 kb_s, s_q_s;
    logic [7:0]                 i_inc_d, j_ksa_d, j_prga_d, pad_addr_d;

    s_mem u_s_mem (
        .address (s_addr_q),
        .clock   (clk),
        .data    (s_data_q),
        .wren    (s_wren_q),
        .q       (s_q_s)
    );

    // Index arithmetic, all modulo 256.
    always_comb begin
        key_ext_s                  = '0;
        key_ext_s[8*KEY_BYTES-1:0] = key_q;
        kb_s       = keybyte(key_ext_s, KEY_NUM, kidx_q);
        i_inc_d    = i_q + 8'd1;
        j_ksa_d    = j_q + s_q_s + kb_s;
        j_prga_d   = j_q + s_q_s;
        pad_addr_d = si_q + sj_q;
    end

    // Control FSM; RAM controls are registered, so each read needs one wait state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rdy_q       <= 1'b1;
            key_q       <= '0;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            kidx_q      <= 8'd0;
            len_q       <= 8'd0;
            si_q        <= 8'd0;
            sj_q        <= 8'd0;
            pt_q        <= 8'd0;
            k_q         <= 9'd0;
            s_addr_q    <= 8'd0;
            s_data_q    <= 8'd0;
            s_wren_q    <= 1'b0;
            pt_addr_q   <= 8'd0;
            ct_addr_q   <= 8'd0;
            ct_wrdata_q <= 8'd0;
            ct_wren_q   <= 1'b0;
        end else begin
            ct_wren_q <= 1'b0;
            s_wren_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus_if.en) begin
                        key_q     <= bus_if.key;
                        rdy_q     <= 1'b0;
                        i_q       <= 8'd0;
                        pt_addr_q <= LEN_ADDR;
                        state_q   <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    s_addr_q <= i_q;
                    s_data_q <= i_q;
                    s_wren_q <= 1'b1;
                    i_q      <= i_inc_d;
                    if (i_inc_d == 8'd0) begin
                        j_q     <= 8'd0;
                        kidx_q  <= 8'd0;
                        state_q <= ST_KSA_READ_SI;
                    end
                end
                ST_KSA_READ_SI: begin
                    s_addr_q <= i_q;
                    state_q  <= ST_KSA_WAIT_SI;
                end
                ST_KSA_WAIT_SI: state_q <= ST_KSA_READ_SJ;
                ST_KSA_READ_SJ: begin
                    si_q     <= s_q_s;
                    j_q      <= j_ksa_d;
                    s_addr_q <= j_ksa_d;
                    state_q  <= ST_KSA_WAIT_SJ;
                end
                ST_KSA_WAIT_SJ: state_q <= ST_KSA_WRITE_SI;
                ST_KSA_WRITE_SI: begin
                    sj_q     <= s_q_s;
                    s_addr_q <= i_q;
                    s_data_q <= s_q_s;
                    s_wren_q <= 1'b1;
                    state_q  <= ST_KSA_WRITE_SJ;
                end
                ST_KSA_WRITE_SJ: begin
                    s_addr_q <= j_q;
                    s_data_q <= si_q;
                    s_wren_q <= 1'b1;
                    i_q      <= i_inc_d;
                    kidx_q   <= (kidx_q == KEY_LAST) ? 8'd0 : kidx_q + 8'd1;
                    state_q  <= (i_q == 8'hFF) ? ST_LEN_READ : ST_KSA_READ_SI;
                end
                ST_LEN_READ: begin
                    pt_addr_q <= LEN_ADDR;
                    state_q   <= ST_LEN_WAIT;
                end
                ST_LEN_WAIT: state_q <= ST_LEN_WRITE;
                ST_LEN_WRITE: begin
                    len_q       <= bus_if.pt_rddata;
                    ct_addr_q   <= LEN_ADDR;
                    ct_wrdata_q <= bus_if.pt_rddata;
                    ct_wren_q   <= 1'b1;
                    i_q         <= 8'd0;
                    j_q         <= 8'd0;
                    k_q         <= 9'd1;
                    state_q     <= (bus_if.pt_rddata == 8'd0) ? ST_DONE : ST_PRGA_READ_SI;
                end
                // PT[k] is fetched alongside S[i] and captured with it.
                ST_PRGA_READ_SI: begin
                    i_q       <= i_inc_d;
                    s_addr_q  <= i_inc_d;
                    pt_addr_q <= k_q[7:0];
                    state_q   <= ST_PRGA_WAIT_SI;
                end
                ST_PRGA_WAIT_SI: state_q <= ST_PRGA_READ_SJ;
                ST_PRGA_READ_SJ: begin
                    si_q     <= s_q_s;
                    pt_q     <= bus_if.pt_rddata;
                    j_q      <= j_prga_d;
                    s_addr_q <= j_prga_d;
                    state_q  <= ST_PRGA_WAIT_SJ;
                end
                ST_PRGA_WAIT_SJ: state_q <= ST_PRGA_WRITE_SI;
                ST_PRGA_WRITE_SI: begin
                    sj_q     <= s_q_s;
                    s_addr_q <= i_q;
                    s_data_q <= s_q_s;
                    s_wren_q <= 1'b1;
                    state_q  <= ST_PRGA_WRITE_SJ;
                end
                ST_PRGA_WRITE_SJ: begin
                    s_addr_q <= j_q;
                    s_data_q <= si_q;
                    s_wren_q <= 1'b1;
                    state_q  <= ST_PRGA_READ_PAD;
                end
                ST_PRGA_READ_PAD: begin
                    s_addr_q <= pad_addr_d;
                    state_q  <= ST_PRGA_WAIT_PAD;
                end
                ST_PRGA_WAIT_PAD: state_q <= ST_PRGA_WRITE_CT;
                ST_PRGA_WRITE_CT: begin
                    ct_addr_q   <= k_q[7:0];
                    ct_wrdata_q <= s_q_s ^ pt_q;
                    ct_wren_q   <= 1'b1;
                    k_q         <= k_q + 9'd1;
                    state_q     <= (k_q == {1'b0, len_q}) ? ST_DONE : ST_PRGA_READ_SI;
                end
                ST_DONE: begin
                    rdy_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    rdy_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_if.rdy       = rdy_q;
    assign bus_if.pt_addr   = pt_addr_q;
    assign bus_if.ct_addr   = ct_addr_q;
    assign bus_if.ct_wrdata = ct_wrdata_q;
    assign bus_if.ct_wren   = ct_wren_q;

endmodule

// File: tb/tb_arc4_encrypt.sv
// Scoreboard bench for arc4_encrypt: expected CT writes are queued at stimulus time, a monitor checks them.
module tb_arc4_encrypt;

    logic clk;
    logic rst;

    arc4_encrypt_if #(.KEY_BYTES(3)) bus ();

    arc4_encrypt #(.KEY_BYTES(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] orig_pt [256];
    logic [7:0] exp_addr [$];
    logic [7:0] exp_data [$];

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    logic [7:0] last_wr_addr = 8'd0;
    logic [7:0] max_pt_addr = 8'd0;

    // Synchronous-read PT memory and write-only CT memory.
    always @(posedge clk) begin
        bus.pt_rddata <= pt_mem[bus.pt_addr];
        if (bus.ct_wren) ct_mem[bus.ct_addr] <= bus.ct_wrdata;
    end

    // Monitor: every CT write must match the head of the expected queue.
    always @(negedge clk) begin
        logic [7:0] ea, ed;
        if (!rst && bus.ct_wren) begin
            wr_cnt++;
            last_wr_addr = bus.ct_addr;
            tests++;
            if (exp_addr.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write got addr=%02h data=%02h, expected no write", bus.ct_addr, bus.ct_wrdata);
            end else begin
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                if (bus.ct_addr !== ea || bus.ct_wrdata !== ed) begin
                    fails++;
                    $display("FAIL ct_write got addr=%02h data=%02h, expected addr=%02h data=%02h",
                             bus.ct_addr, bus.ct_wrdata, ea, ed);
                end
            end
        end
        if (!rst && !bus.rdy && bus.pt_addr > max_pt_addr) max_pt_addr = bus.pt_addr;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference ARC4 over the current pt_mem; pushes the full expected write sequence.
    task automatic model_push(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] i, j, t, len;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            j = j + s[n] + kb[n % 3];
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        len = pt_mem[0];
        exp_addr.push_back(8'd0);
        exp_data.push_back(len);
        i = 8'd0;
        j = 8'd0;
        for (int k = 1; k <= int'(len); k++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[i] + s[j];
            exp_addr.push_back(8'(k));
            exp_data.push_back(pt_mem[k] ^ s[t]);
        end
    endtask

    task automatic push_vec1();
        logic [7:0] v [10];
        v = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        for (int n = 0; n < 10; n++) begin
            exp_addr.push_back(8'(n));
            exp_data.push_back(v[n]);
        end
    endtask

    task automatic load_plaintext();
        logic [7:0] p [10];
        p = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        for (int n = 0; n < 10; n++) pt_mem[n] = p[n];
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!bus.rdy && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("rdy_return", 32'(bus.rdy), 32'd1);
    endtask

    task automatic do_run(input logic [23:0] k);
        bus.key = k;
        bus.en  = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        wait_rdy();
    endtask

    initial begin
        int base, n, mism;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.key = 24'h0;
        for (int a = 0; a < 256; a++) begin
            pt_mem[a] = 8'h00;
            ct_mem[a] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("reset_rdy", 32'(bus.rdy), 32'd1);
        check("reset_ct_wren", 32'(bus.ct_wren), 32'd0);
        check("reset_ct_addr", 32'(bus.ct_addr), 32'd0);
        check("reset_ct_wrdata", 32'(bus.ct_wrdata), 32'd0);
        check("reset_pt_addr", 32'(bus.pt_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Known-answer vector "Key" / "Plaintext".
        load_plaintext();
        push_vec1();
        base = wr_cnt;
        do_run(24'h4B6579);
        check("kat_writes", 32'(wr_cnt - base), 32'd10);
        check("kat_queue_empty", 32'(exp_addr.size()), 32'd0);

        // Empty message.
        pt_mem[0] = 8'h00;
        exp_addr.push_back(8'h00);
        exp_data.push_back(8'h00);
        base = wr_cnt;
        max_pt_addr = 8'd0;
        do_run(24'h123456);
        check("len0_writes", 32'(wr_cnt - base), 32'd1);
        check("len0_max_pt_addr", 32'(max_pt_addr), 32'd0);
        check("len0_queue_empty", 32'(exp_addr.size()), 32'd0);

        // Maximum length, then round trip back to plaintext.
        pt_mem[0] = 8'hFF;
        for (int a = 1; a < 256; a++) pt_mem[a] = 8'($urandom_range(0, 255));
        for (int a = 0; a < 256; a++) orig_pt[a] = pt_mem[a];
        model_push(24'h000018);
        base = wr_cnt;
        do_run(24'h000018);
        check("len255_writes", 32'(wr_cnt - base), 32'd256);
        check("len255_last_addr", 32'(last_wr_addr), 32'hFF);
        check("len255_queue_empty", 32'(exp_addr.size()), 32'd0);
        for (int a = 0; a < 256; a++) pt_mem[a] = ct_mem[a];
        model_push(24'h000018);
        do_run(24'h000018);
        mism = 0;
        for (int a = 0; a < 256; a++) if (ct_mem[a] !== orig_pt[a]) mism++;
        check("roundtrip_mismatches", 32'(mism), 32'd0);

        // en held high across two back-to-back runs with different keys.
        load_plaintext();
        model_push(24'h010203);
        model_push(24'hA5C3F0);
        base = wr_cnt;
        bus.key = 24'h010203;
        bus.en = 1'b1;
        @(negedge clk);
        bus.key = 24'hA5C3F0;
        n = 0;
        while (!bus.rdy && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_done", 32'(bus.rdy), 32'd1);
        check("b2b_first_writes", 32'(wr_cnt - base), 32'd10);
        @(negedge clk);
        bus.en = 1'b0;
        check("b2b_second_started", 32'(bus.rdy), 32'd0);
        wait_rdy();
        check("b2b_total_writes", 32'(wr_cnt - base), 32'd20);
        check("b2b_queue_empty", 32'(exp_addr.size()), 32'd0);

        // Reset in the middle of key scheduling, then a clean run.
        bus.key = 24'h4B6579;
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (400) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rdy", 32'(bus.rdy), 32'd1);
        check("abort_ct_wren", 32'(bus.ct_wren), 32'd0);
        push_vec1();
        base = wr_cnt;
        do_run(24'h4B6579);
        check("after_abort_writes", 32'(wr_cnt - base), 32'd10);
        check("after_abort_queue_empty", 32'(exp_addr.size()), 32'd0);

        // en pulses with another key during PRGA must be ignored.
        push_vec1();
        base = wr_cnt;
        bus.key = 24'h4B6579;
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        n = 0;
        while (wr_cnt - base < 2 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("prga_reached", 32'(wr_cnt - base), 32'd2);
        bus.key = 24'hFFFFFF;
        bus.en = 1'b1;
        repeat (3) @(negedge clk);
        bus.en = 1'b0;
        wait_rdy();
        check("ignored_en_writes", 32'(wr_cnt - base), 32'd10);
        check("ignored_en_queue_empty", 32'(exp_addr.size()), 32'd0);
        check("ignored_en_idle", 32'(bus.rdy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
